// File: rtl/codemem_loader.sv
// -----------------------------------------------------------------------------
// codemem_loader
//   Instruction memory for the i281 core with an integrated program loader.
//   After reset the array is cleared to zero one word per cycle. A host then
//   streams blocks of instruction words over a valid/ready interface. Each
//   block is written at consecutive addresses, wrapping modulo DEPTH. The CPU
//   fetch port has a one-cycle registered read and a valid flag. When a fetch
//   and a load write hit the same address in the same cycle, BYPASS selects
//   whether the fetch sees the new word or the old one.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   load_start   request a load block (honoured only in IDLE)
//   load_base    first write address of the block
//   load_count   number of words in the block, legal range 1..DEPTH
//   load_valid   load_data carries a word this cycle
//   load_data    instruction word to write
//   load_ready   loader accepts a word this cycle (state == LOAD)
//   load_busy    loader not idle (CLEAR or LOAD)
//   load_done    one-cycle pulse after the last word of a block is written
//   load_error   one-cycle pulse when a load_start is rejected
//   fetch_en     fetch request
//   fetch_addr   fetch address
//   fetch_data   registered fetch result
//   fetch_valid  fetch_data comes from the previous cycle's fetch
// -----------------------------------------------------------------------------
module codemem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  // DEPTH expressed in the (ADDR_W+1)-bit width of load_count.
  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] clr_addr_q,  clr_addr_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;

  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;

  // Storage array; written through a single port, read through the fetch port.
  logic [DATA_W-1:0] mem [DEPTH];

  // Single shared write port: clear and load never write in the same cycle.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic count_ok;

  assign count_ok = (load_count != '0) && (load_count <= DEPTH_CNT);

  // ---------------------------------------------------------------------------
  // Next-state and write-port logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q;
    mem_wdata   = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + ADDR_ONE;
        if (clr_addr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (load_start) begin
          if (count_ok) begin
            wr_addr_d   = load_base;
            remaining_d = load_count;
            state_d     = ST_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        // load_ready is 1 throughout LOAD, so load_valid alone is a handshake.
        if (load_valid) begin
          mem_we      = 1'b1;
          mem_waddr   = wr_addr_q;
          mem_wdata   = load_data;
          wr_addr_d   = wr_addr_q + ADDR_ONE;  // wraps modulo DEPTH
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port. The reset cycle leaves contents untouched, including a
  // word that happens to be presented while a LOAD is being aborted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch port: registered read. Fetches are suppressed while clearing so the
  // CPU never sees a partially cleared array. fetch_data holds when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      fetch_valid_q <= 1'b0;
    end else if (fetch_en) begin
      fetch_valid_q <= 1'b1;
      // Outside CLEAR the write port is only driven by the loader, so this
      // forwards the word being loaded this very cycle.
      if (BYPASS && mem_we && (mem_waddr == fetch_addr)) begin
        fetch_data_q <= mem_wdata;
      end else begin
        fetch_data_q <= mem[fetch_addr];
      end
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign load_ready  = (state_q == ST_LOAD);
  assign load_busy   = (state_q != ST_IDLE);
  assign load_done   = done_q;
  assign load_error  = error_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;

endmodule
